// File: rtl/mem_access_stage.sv
// RV32I memory stage: drives the data bus for loads and stores, aligns store data, extends load
// data and owns the MEM/WB register, inserting bubbles while an access is outstanding.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regWrtm,
  input  logic        memWrtm,
  input  logic        readm,
  input  logic [1:0]  rsltSrcm,
  input  logic [2:0]  funct3m,
  input  logic [31:0] aluRsltm,
  input  logic [31:0] wrtDm,
  input  logic [31:0] pc4m,
  input  logic [31:0] ujWrtBckm,
  input  logic [4:0]  rdm,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [31:0] dWData,
  output logic [3:0]  dBe,
  input  logic        dGnt,
  input  logic        dRValid,
  input  logic [31:0] dRData,
  input  logic        dErr,
  output logic        stallm,
  output logic        excMisalign,
  output logic        excBusErr,
  output logic        regWrtw,
  output logic [1:0]  rsltSrcw,
  output logic [31:0] aluRsltw,
  output logic [31:0] readDw,
  output logic [31:0] pc4w,
  output logic [31:0] ujWrtBckw,
  output logic [4:0]  rdw
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        access, misaligned, mis_evt;
  logic        req, stall, load_gnt, bus_err, wb_bubble;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign access  = readm | memWrtm;
  assign mis_evt = (state_q == StIdle) & access & misaligned;

  always_comb begin
    case (funct3m[1:0])
      2'b01:   misaligned = aluRsltm[0];
      2'b10:   misaligned = |aluRsltm[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    stall    = 1'b0;
    load_gnt = 1'b0;
    bus_err  = 1'b0;
    unique case (state_q)
      StIdle, StReq: begin
        req = (state_q == StReq) | (access & ~misaligned);
        if (req) begin
          if (dGnt && memWrtm) begin
            state_d = StIdle;
            bus_err = dErr;
          end else if (dGnt) begin
            state_d  = StResp;
            cnt_d    = '0;
            load_gnt = 1'b1;
            stall    = 1'b1;
          end else begin
            state_d = StReq;
            stall   = 1'b1;
          end
        end
      end
      StResp: begin
        if (dRValid) begin
          state_d = StIdle;
          bus_err = dErr;
          cnt_d   = '0;
        end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
          // Watchdog abort: release the pipeline with a bubble instead of the load.
          state_d = StIdle;
          bus_err = 1'b1;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (funct3m[1:0])
      2'b00: begin
        be    = 4'b0001 << aluRsltm[1:0];
        wdata = {4{wrtDm[7:0]}};
      end
      2'b01: begin
        be    = aluRsltm[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wrtDm[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wrtDm;
      end
    endcase
  end

  always_comb begin
    ld_byte = dRData[8*off_q +: 8];
    ld_half = off_q[1] ? dRData[31:16] : dRData[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dRData;
    endcase
  end

  // Bus and stall are gated by rst_n so they drop the instant reset asserts.
  assign dReq      = rst_n & req;
  assign stallm    = rst_n & stall;
  assign dWe       = dReq & memWrtm;
  assign dAddr     = dReq ? {aluRsltm[31:2], 2'b00} : '0;
  assign dWData    = dReq ? wdata : '0;
  assign dBe       = dReq ? be : '0;
  assign wb_bubble = stall | mis_evt | bus_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_gnt) begin
        off_q <= aluRsltm[1:0];
        f3_q  <= funct3m;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      excMisalign <= 1'b0;
      excBusErr   <= 1'b0;
      regWrtw     <= 1'b0;
      rsltSrcw    <= '0;
      aluRsltw    <= '0;
      readDw      <= '0;
      pc4w        <= '0;
      ujWrtBckw   <= '0;
      rdw         <= '0;
    end else begin
      excMisalign <= mis_evt;
      excBusErr   <= bus_err;
      if (wb_bubble) begin
        regWrtw <= 1'b0;
        rdw     <= '0;
      end else begin
        regWrtw   <= regWrtm;
        rsltSrcw  <= rsltSrcm;
        aluRsltw  <= aluRsltm;
        readDw    <= load_data;
        pc4w      <= pc4m;
        ujWrtBckw <= ujWrtBckm;
        rdw       <= rdm;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts bus, stall and MEM/WB
// behaviour per instruction; a negedge compare process checks it, plus literal pins.
module tb_mem_access_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWrtm, memWrtm, readm;
  logic [1:0]  rsltSrcm;
  logic [2:0]  funct3m;
  logic [31:0] aluRsltm, wrtDm, pc4m, ujWrtBckm;
  logic [4:0]  rdm;
  logic        dReq, dWe;
  logic [31:0] dAddr, dWData;
  logic [3:0]  dBe;
  logic        dGnt, dRValid, dErr;
  logic [31:0] dRData;
  logic        stallm, excMisalign, excBusErr, regWrtw;
  logic [1:0]  rsltSrcw;
  logic [31:0] aluRsltw, readDw, pc4w, ujWrtBckw;
  logic [4:0]  rdw;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .regWrtm(regWrtm), .memWrtm(memWrtm), .readm(readm),
    .rsltSrcm(rsltSrcm), .funct3m(funct3m), .aluRsltm(aluRsltm), .wrtDm(wrtDm), .pc4m(pc4m),
    .ujWrtBckm(ujWrtBckm), .rdm(rdm), .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
    .dBe(dBe), .dGnt(dGnt), .dRValid(dRValid), .dRData(dRData), .dErr(dErr), .stallm(stallm),
    .excMisalign(excMisalign), .excBusErr(excBusErr), .regWrtw(regWrtw), .rsltSrcw(rsltSrcw),
    .aluRsltw(aluRsltw), .readDw(readDw), .pc4w(pc4w), .ujWrtBckw(ujWrtBckw), .rdw(rdw)
  );

  typedef struct {
    logic        regw, st, ld, err;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, wdata, rdata;
    int          g, r;  // grant cycle; response delay after grant (0 = never)
  } vec_t;

  typedef struct {
    int          mode;  // 0 none, 1 capture, 2 bubble
    logic        regw, load, mis, berr;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu, rdv, pc4, uj;
  } wb_t;

  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 0;
  logic exp_stall, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wd;
  logic [3:0]  exp_be;
  wb_t  cur, pend;
  logic [7:0]  snap_stall;
  logic        snap_req;
  logic [3:0]  snap_be;
  logic [31:0] snap_wd, snap_addr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = '0;
    for (int i = 0; i < m_size(f3); i++) be[int'(a[1:0]) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % m_size(f3)) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    int n = m_size(f3);
    logic [31:0] v, mask;
    if (n >= 4) return d;
    v    = d >> (8 * int'(a[1:0]));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic vec_t mk(input logic regw, input logic st, input logic ld,
                              input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int g,
                              input int r, input logic err);
    vec_t v;
    v.regw = regw; v.st = st; v.ld = ld; v.f3 = f3; v.rd = rd; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.g = g; v.r = r; v.err = err;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("stallm", 32'(stallm), 32'(exp_stall));
      cmp("dReq", 32'(dReq), 32'(exp_req));
      if (exp_req) begin
        cmp("dWe", 32'(dWe), 32'(exp_we));
        cmp("dAddr", dAddr, exp_addr);
        if (exp_we) begin
          cmp("dBe", 32'(dBe), 32'(exp_be));
          cmp("dWData", dWData, exp_wd);
        end
      end
      if (cur.mode != 0) begin
        cmp("excMisalign", 32'(excMisalign), 32'(cur.mis));
        cmp("excBusErr", 32'(excBusErr), 32'(cur.berr));
        if (cur.mode == 1) begin
          cmp("regWrtw", 32'(regWrtw), 32'(cur.regw));
          cmp("rdw", 32'(rdw), 32'(cur.rd));
          cmp("rsltSrcw", 32'(rsltSrcw), 32'(cur.src));
          cmp("aluRsltw", aluRsltw, cur.alu);
          cmp("pc4w", pc4w, cur.pc4);
          cmp("ujWrtBckw", ujWrtBckw, cur.uj);
          if (cur.load) cmp("readDw", readDw, cur.rdv);
        end else begin
          cmp("bubble_regWrtw", 32'(regWrtw), 32'd0);
          cmp("bubble_rdw", 32'(rdw), 32'd0);
        end
      end
    end
  end

  task automatic drive_nop();
    regWrtm = 0; memWrtm = 0; readm = 0; rsltSrcm = '0; funct3m = '0; aluRsltm = '0;
    wrtDm = '0; pc4m = '0; ujWrtBckm = '0; rdm = '0;
    dGnt = 0; dRValid = 0; dRData = '0; dErr = 0;
  endtask

  task automatic run_op(input vec_t v);
    logic access, store, load, mis;
    int   done;
    bit   abort;
    wb_t  w;
    store  = v.st;
    load   = v.ld & ~v.st;
    access = v.ld | v.st;
    mis    = access && m_mis(v.f3, v.addr);
    abort  = 0;
    if (!access || mis) done = 0;
    else if (store) done = v.g;
    else if (v.r == 0 || v.r > int'(TO)) begin
      done  = v.g + int'(TO);
      abort = 1;
    end else done = v.g + v.r;
    snap_stall = '0;
    for (int k = 0; k <= done; k++) begin
      regWrtm = v.regw; memWrtm = v.st; readm = v.ld; funct3m = v.f3; aluRsltm = v.addr;
      wrtDm = v.wdata; rdm = v.rd; rsltSrcm = v.rd[1:0]; pc4m = v.addr + 32'd4;
      ujWrtBckm = ~v.addr;
      dGnt    = access && !mis && k == v.g;
      dRValid = (load && !mis && !abort && v.r != 0 && k == v.g + v.r) ||
                (!access && v.r != 0 && k == 0);
      dRData  = dRValid ? v.rdata : 32'hDEAD_BEEF;
      dErr    = v.err && (dRValid || (dGnt && store));
      exp_stall = k < done;
      exp_req   = access && !mis && k <= v.g;
      exp_we    = store;
      exp_addr  = v.addr & ~32'h3;
      exp_be    = m_be(v.f3, v.addr);
      exp_wd    = m_wd(v.f3, v.wdata);
      if (k == 0) cur = pend;
      else begin
        cur.mode = 2; cur.mis = 0; cur.berr = 0;
      end
      chk_on = 1;
      @(negedge clk);
      if (k < 8) snap_stall[k] = stallm;
      if (k == 0) begin
        snap_req = dReq; snap_be = dBe; snap_wd = dWData; snap_addr = dAddr;
      end
      @(posedge clk);
      #1;
    end
    w.mis = mis; w.berr = 0; w.load = load;
    w.regw = v.regw; w.rd = v.rd; w.src = v.rd[1:0]; w.alu = v.addr;
    w.pc4 = v.addr + 32'd4; w.uj = ~v.addr; w.rdv = m_load(v.f3, v.addr, v.rdata);
    if (mis) w.mode = 2;
    else if (abort || (access && v.err)) begin
      w.mode = 2; w.berr = 1;
    end else w.mode = 1;
    pend = w;
  endtask

  initial begin
    pend.mode = 0;
    cur.mode  = 0;
    drive_nop();
    rst_n = 0;
    readm = 1; regWrtm = 1; aluRsltm = 32'h10;  // access held during reset must not reach the bus
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_dReq", 32'(dReq), 32'd0);
    cmp("rst_stallm", 32'(stallm), 32'd0);
    cmp("rst_regWrtw", 32'(regWrtw), 32'd0);
    cmp("rst_aluRsltw", aluRsltw, 32'd0);
    cmp("rst_readDw", readDw, 32'd0);
    drive_nop();
    rst_n = 1;
    @(posedge clk);
    #1;

    run_op(mk(1, 0, 0, 3'b000, 5'd5, 32'h1234, 0, 0, 0, 0, 0));
    cmp("alu_regWrtw", 32'(regWrtw), 32'd1);
    cmp("alu_rdw", 32'(rdw), 32'd5);
    cmp("alu_aluRsltw", aluRsltw, 32'h1234);
    cmp("alu_stall", 32'(snap_stall[0]), 32'd0);

    run_op(mk(0, 1, 0, 3'b000, 5'd1, 32'h103, 32'hAB, 0, 0, 0, 0));
    cmp("sb_dBe", 32'(snap_be), 32'b1000);
    cmp("sb_dWData", snap_wd, 32'hABABABAB);
    cmp("sb_dAddr", snap_addr, 32'h100);
    cmp("sb_stall", 32'(snap_stall[0]), 32'd0);

    run_op(mk(1, 0, 1, 3'b000, 5'd6, 32'h102, 0, 32'h0080_0000, 0, 3, 0));
    cmp("lb_stall_hist", 32'(snap_stall[3:0]), 32'b0111);
    cmp("lb_readDw", readDw, 32'hFFFFFF80);

    run_op(mk(1, 0, 1, 3'b101, 5'd7, 32'h101, 0, 0, 0, 0, 0));
    cmp("lhu_mis_req", 32'(snap_req), 32'd0);
    cmp("lhu_excMisalign", 32'(excMisalign), 32'd1);
    cmp("lhu_regWrtw", 32'(regWrtw), 32'd0);

    run_op(mk(0, 1, 0, 3'b001, 5'd2, 32'h202, 32'h1234ABCD, 0, 2, 0, 0));
    run_op(mk(1, 0, 1, 3'b001, 5'd8, 32'h206, 0, 32'h8001_7FFF, 1, 1, 0));
    run_op(mk(1, 0, 1, 3'b101, 5'd9, 32'h106, 0, 32'h8001_7FFF, 0, 2, 0));
    run_op(mk(1, 0, 1, 3'b100, 5'd10, 32'h101, 0, 32'h0000_C300, 0, 1, 0));
    cmp("lbu_readDw", readDw, 32'h000000C3);
    run_op(mk(0, 1, 0, 3'b010, 5'd3, 32'h300, 32'hCAFEF00D, 0, 0, 0, 0));
    run_op(mk(1, 0, 1, 3'b010, 5'd11, 32'h300, 0, 32'h1234_5678, 0, 4, 0));
    cmp("lw_edge_readDw", readDw, 32'h12345678);
    run_op(mk(0, 1, 0, 3'b010, 5'd4, 32'h302, 32'h1, 0, 0, 0, 0));
    run_op(mk(1, 0, 1, 3'b010, 5'd12, 32'h40, 0, 32'h5555_AAAA, 0, 1, 1));
    run_op(mk(0, 1, 0, 3'b000, 5'd13, 32'h44, 32'h77, 0, 0, 0, 1));

    run_op(mk(1, 0, 1, 3'b010, 5'd14, 32'h200, 0, 0, 1, 0, 0));
    cmp("to_stall_hist", 32'(snap_stall[5:0]), 32'b011111);
    cmp("to_excBusErr", 32'(excBusErr), 32'd1);
    cmp("to_regWrtw", 32'(regWrtw), 32'd0);
    run_op(mk(1, 0, 0, 3'b000, 5'd15, 32'h55, 0, 32'h1, 0, 1, 1));
    cmp("late_rv_excBusErr", 32'(excBusErr), 32'd0);
    cmp("late_rv_regWrtw", 32'(regWrtw), 32'd1);
    run_op(mk(1, 0, 0, 3'b000, 5'd9, 32'h9999, 0, 0, 0, 0, 0));

    // Reset while a load sits in REQ.
    chk_on = 0;
    regWrtm = 1; readm = 1; memWrtm = 0; funct3m = 3'b010; aluRsltm = 32'h400; rdm = 5'd16;
    dGnt = 0; dRValid = 0; dErr = 0;
    @(posedge clk);
    #1;
    cmp("req_before_reset", 32'(dReq), 32'd1);
    rst_n = 0;
    #1;
    cmp("mid_rst_dReq", 32'(dReq), 32'd0);
    cmp("mid_rst_stallm", 32'(stallm), 32'd0);
    cmp("mid_rst_aluRsltw", aluRsltw, 32'd0);
    cmp("mid_rst_rdw", 32'(rdw), 32'd0);
    drive_nop();
    @(posedge clk);
    #1;
    rst_n = 1;
    pend.mode = 0;
    @(posedge clk);
    #1;
    run_op(mk(1, 0, 0, 3'b000, 5'd3, 32'hBEEF, 0, 0, 0, 0, 0));
    cmp("post_rst_regWrtw", 32'(regWrtw), 32'd1);
    cmp("post_rst_rdw", 32'(rdw), 32'd3);
    cmp("post_rst_aluRsltw", aluRsltw, 32'hBEEF);
    run_op(mk(0, 0, 0, 3'b000, 5'd0, 32'h0, 0, 0, 0, 0, 0));
    chk_on = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
